// File: rtl/calc_pkg.sv
// Shared definitions for the BCD calculator sequencing controller:
// key codes, ALU op/enable encodings and controller states.
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_EQ  = 4'hC;
  localparam logic [3:0] KEY_CE  = 4'hD;

  localparam logic [1:0] OP_NONE    = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b01;
  localparam logic [1:0] OP_SUB     = 2'b10;
  localparam logic [1:0] ALU_EN_ON  = 2'b01;
  localparam logic [1:0] ALU_EN_OFF = 2'b00;

  typedef enum logic [2:0] {ENTER_A, ENTER_B, EXEC, WAIT, SHOW} state_t;

  function automatic logic isDigit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

  function automatic logic isOpKey(input logic [3:0] code);
    return (code == KEY_ADD) || (code == KEY_SUB);
  endfunction

endpackage

// File: rtl/calc_controller_if.sv
// Keypad, ALU and display signals of the calculator controller, bundled.
// master = controller side, slave = keypad/ALU/display side.
interface calc_controller_if;

  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic [15:0] bcd1;
  logic [15:0] bcd2;
  logic [1:0]  op_selected;
  logic [1:0]  alu_enable;
  logic [15:0] alu_bcd_out;
  logic        alu_special;
  logic [15:0] disp_bcd;
  logic        disp_neg;
  logic        busy;

  modport master (
    input  key_valid, key_code, alu_bcd_out, alu_special,
    output key_ready, bcd1, bcd2, op_selected, alu_enable, disp_bcd, disp_neg, busy
  );

  modport slave (
    output key_valid, key_code, alu_bcd_out, alu_special,
    input  key_ready, bcd1, bcd2, op_selected, alu_enable, disp_bcd, disp_neg, busy
  );

endinterface

// File: rtl/bcd_entry_reg.sv
// BCD operand entry register: digits shift in at the low nibble, with
// clear, parallel load, digit count and full/empty flags.
module bcd_entry_reg #(
  parameter int MAX_DIGITS = 3,
  localparam int CW = $clog2(MAX_DIGITS + 1)
) (
  input  logic          clk,
  input  logic          clear_n,
  input  logic          i_clear,
  input  logic          i_load,
  input  logic [15:0]   i_loadVal,
  input  logic [CW-1:0] i_loadCnt,
  input  logic          i_shift,
  input  logic [3:0]    i_digit,
  output logic [15:0]   o_value,
  output logic          o_full,
  output logic          o_empty
);

  localparam logic [15:0]   VAL_MASK = 16'((32'd1 << (4 * MAX_DIGITS)) - 32'd1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_DIGITS);

  logic [15:0]   r_value;
  logic [CW-1:0] r_count;
  logic [15:0]   w_shifted;

  assign w_shifted = {r_value[11:0], i_digit} & VAL_MASK;
  assign o_full    = (r_count == CNT_MAX);
  assign o_empty   = (r_count == '0);
  assign o_value   = r_value;

  // Once full, further digits are dropped so the operand never exceeds its width
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_value <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_value <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_value <= i_loadVal & VAL_MASK;
      r_count <= i_loadCnt;
    end else if (i_shift && !o_full) begin
      r_value <= w_shifted;
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/calc_controller.sv
// Calculator sequencing controller: assembles two BCD operands and an op
// from keypad events, pulses the ALU once and captures its result for display.
module calc_controller
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = 3,
  parameter int ALU_LAT    = 1
) (
  input  logic          clk,
  input  logic          clear_n,
  calc_controller_if.master bus
);

  localparam int          CW        = $clog2(MAX_DIGITS + 1);
  localparam logic [2:0]  WAIT_LOAD = 3'(ALU_LAT);

  state_t        r_state, w_next;
  logic [2:0]    r_wait;
  logic [1:0]    r_op;
  logic [15:0]   r_dispBcd;
  logic          r_dispNeg;

  logic [15:0]   w_aValue, w_bValue, w_aLoadVal, w_dispBcd;
  logic [CW-1:0] w_aLoadCnt;
  logic          w_aFull, w_bFull, w_aEmpty, w_bEmpty;
  logic          w_aClear, w_aLoad, w_aShift, w_bClear, w_bShift;
  logic          w_opLoad, w_opClear, w_dispClear, w_capture;
  logic          w_ready, w_accept, w_dispNeg;
  logic [1:0]    w_keyOp;

  bcd_entry_reg #(.MAX_DIGITS(MAX_DIGITS)) u_entryA (
    .clk(clk), .clear_n(clear_n), .i_clear(w_aClear), .i_load(w_aLoad),
    .i_loadVal(w_aLoadVal), .i_loadCnt(w_aLoadCnt), .i_shift(w_aShift),
    .i_digit(bus.key_code), .o_value(w_aValue), .o_full(w_aFull), .o_empty(w_aEmpty)
  );

  bcd_entry_reg #(.MAX_DIGITS(MAX_DIGITS)) u_entryB (
    .clk(clk), .clear_n(clear_n), .i_clear(w_bClear), .i_load(1'b0),
    .i_loadVal(16'h0000), .i_loadCnt('0), .i_shift(w_bShift),
    .i_digit(bus.key_code), .o_value(w_bValue), .o_full(w_bFull), .o_empty(w_bEmpty)
  );

  assign w_ready  = (r_state == ENTER_A) || (r_state == ENTER_B) || (r_state == SHOW);
  assign w_accept = bus.key_valid && w_ready;
  assign w_keyOp  = (bus.key_code == KEY_SUB) ? OP_SUB : OP_ADD;

  always_comb begin
    w_next      = r_state;
    w_aClear    = 1'b0;
    w_aLoad     = 1'b0;
    w_aShift    = 1'b0;
    w_aLoadVal  = {12'h000, bus.key_code};
    w_aLoadCnt  = CW'(1);
    w_bClear    = 1'b0;
    w_bShift    = 1'b0;
    w_opLoad    = 1'b0;
    w_opClear   = 1'b0;
    w_dispClear = 1'b0;
    w_capture   = 1'b0;
    if (w_accept && bus.key_code == KEY_CE) begin
      w_aClear    = 1'b1;
      w_bClear    = 1'b1;
      w_opClear   = 1'b1;
      w_dispClear = 1'b1;
      w_next      = ENTER_A;
    end else begin
      case (r_state)
        ENTER_A: if (w_accept) begin
          if (isDigit(bus.key_code)) begin
            w_aShift = !w_aFull;
          end else if (isOpKey(bus.key_code)) begin
            w_opLoad = 1'b1;
            w_bClear = 1'b1;
            w_next   = ENTER_B;
          end
        end
        ENTER_B: if (w_accept) begin
          if (isDigit(bus.key_code)) begin
            w_bShift = !w_bFull;
          end else if (isOpKey(bus.key_code)) begin
            w_opLoad = w_bEmpty;
          end else if (bus.key_code == KEY_EQ) begin
            w_next = EXEC;
          end
        end
        EXEC: w_next = WAIT;
        WAIT: if (r_wait <= 3'd1) begin
          w_capture = 1'b1;
          w_next    = SHOW;
        end
        SHOW: if (w_accept) begin
          if (isDigit(bus.key_code)) begin
            w_aLoad   = 1'b1;
            w_bClear  = 1'b1;
            w_opClear = 1'b1;
            w_next    = ENTER_A;
          end else if (isOpKey(bus.key_code) && !r_dispNeg && r_dispBcd[15:12] == 4'h0) begin
            // Chaining reuses the result as operand A; only results that fit are allowed
            w_aLoad    = 1'b1;
            w_aLoadVal = r_dispBcd;
            w_aLoadCnt = CW'(MAX_DIGITS);
            w_bClear   = 1'b1;
            w_opLoad   = 1'b1;
            w_next     = ENTER_B;
          end else if (bus.key_code == KEY_EQ) begin
            w_next = EXEC;
          end
        end
        default: w_next = ENTER_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) r_state <= ENTER_A;
    else          r_state <= w_next;
  end

  // Display register tracks the entry value so EXEC/WAIT keep showing it
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_op      <= OP_NONE;
      r_wait    <= 3'd0;
      r_dispBcd <= 16'h0000;
      r_dispNeg <= 1'b0;
    end else begin
      if (w_opClear)     r_op <= OP_NONE;
      else if (w_opLoad) r_op <= w_keyOp;
      if (r_state == EXEC)      r_wait <= WAIT_LOAD;
      else if (r_state == WAIT) r_wait <= r_wait - 3'd1;
      if (w_dispClear) begin
        r_dispBcd <= 16'h0000;
        r_dispNeg <= 1'b0;
      end else if (w_capture) begin
        r_dispBcd <= bus.alu_bcd_out;
        r_dispNeg <= bus.alu_special;
      end else if (r_state == ENTER_A || r_state == ENTER_B) begin
        r_dispBcd <= w_dispBcd;
        r_dispNeg <= 1'b0;
      end
    end
  end

  always_comb begin
    w_dispBcd = r_dispBcd;
    w_dispNeg = r_dispNeg;
    case (r_state)
      ENTER_A: begin w_dispBcd = w_aValue; w_dispNeg = 1'b0; end
      ENTER_B: begin w_dispBcd = w_bValue; w_dispNeg = 1'b0; end
      default: ;
    endcase
  end

  assign bus.key_ready   = w_ready && clear_n && !(w_aEmpty && 1'b0);
  assign bus.bcd1        = w_aValue;
  assign bus.bcd2        = w_bValue;
  assign bus.op_selected = r_op;
  assign bus.alu_enable  = (r_state == EXEC) ? ALU_EN_ON : ALU_EN_OFF;
  assign bus.busy        = (r_state == EXEC) || (r_state == WAIT);
  assign bus.disp_bcd    = w_dispBcd;
  assign bus.disp_neg    = w_dispNeg;

endmodule

// File: tb/tb_calc_controller.sv
// Self-checking bench for calc_controller: directed key vectors on an
// ALU_LAT=1 instance plus latency and reset sequences on an ALU_LAT=4 one.
module tb_calc_controller;
  import calc_pkg::*;

  logic clk = 1'b0;
  logic clear_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int enTotal1 = 0;
  int enTotal4 = 0;
  logic [16:0] pipe1;
  logic [16:0] pipe4 [4];

  typedef struct {
    logic [3:0]  key;
    state_t      st;
    logic [15:0] bcd1;
    logic [15:0] bcd2;
    logic [1:0]  op;
    logic [15:0] disp;
    logic        neg;
    int          en;
  } vec_t;
  vec_t vecs[$];

  calc_controller_if bus1();
  calc_controller_if bus4();

  calc_controller #(.MAX_DIGITS(3), .ALU_LAT(1)) dut1 (.clk(clk), .clear_n(clear_n), .bus(bus1));
  calc_controller #(.MAX_DIGITS(3), .ALU_LAT(4)) dut4 (.clk(clk), .clear_n(clear_n), .bus(bus4));

  always #5 clk = ~clk;

  function automatic int bcdToInt(input logic [15:0] v);
    return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [15:0] intToBcd(input int n);
    return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic [16:0] aluModel(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    int r;
    r = (op == OP_SUB) ? bcdToInt(a) - bcdToInt(b) : bcdToInt(a) + bcdToInt(b);
    return {r < 0, intToBcd(r < 0 ? -r : r)};
  endfunction

  // Behavioural ALUs: result appears ALU_LAT edges after the enable is sampled
  always @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      pipe1 <= '0;
      for (int i = 0; i < 4; i++) pipe4[i] <= '0;
    end else begin
      if (bus1.alu_enable == ALU_EN_ON) pipe1 <= aluModel(bus1.bcd1, bus1.bcd2, bus1.op_selected);
      if (bus4.alu_enable == ALU_EN_ON) pipe4[0] <= aluModel(bus4.bcd1, bus4.bcd2, bus4.op_selected);
      for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
    end
  end

  assign bus1.alu_bcd_out = pipe1[15:0];
  assign bus1.alu_special = pipe1[16];
  assign bus4.alu_bcd_out = pipe4[3][15:0];
  assign bus4.alu_special = pipe4[3][16];

  always @(posedge clk) begin
    if (bus1.alu_enable == ALU_EN_ON) enTotal1 <= enTotal1 + 1;
    if (bus4.alu_enable == ALU_EN_ON) enTotal4 <= enTotal4 + 1;
  end

  task automatic setKey(input logic valid, input logic [3:0] code);
    bus1.key_valid = valid;
    bus1.key_code  = code;
    bus4.key_valid = valid;
    bus4.key_code  = code;
  endtask

  task automatic applyStimulus(input logic [3:0] code);
    @(negedge clk);
    setKey(1'b1, code);
    @(negedge clk);
    setKey(1'b0, 4'h0);
    repeat (8) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic [3:0] k, input state_t s, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] op, input logic [15:0] d, input logic n, input int en);
    vecs.push_back('{k, s, a, b, op, d, n, en});
  endtask

  initial begin
    setKey(1'b0, 4'h0);
    addVec(4'h1, ENTER_A, 16'h0001, 16'h0000, OP_NONE, 16'h0001, 1'b0, 0);
    addVec(4'h2, ENTER_A, 16'h0012, 16'h0000, OP_NONE, 16'h0012, 1'b0, 0);
    addVec(4'h3, ENTER_A, 16'h0123, 16'h0000, OP_NONE, 16'h0123, 1'b0, 0);
    addVec(KEY_ADD, ENTER_B, 16'h0123, 16'h0000, OP_ADD, 16'h0000, 1'b0, 0);
    addVec(4'h4, ENTER_B, 16'h0123, 16'h0004, OP_ADD, 16'h0004, 1'b0, 0);
    addVec(4'h5, ENTER_B, 16'h0123, 16'h0045, OP_ADD, 16'h0045, 1'b0, 0);
    addVec(KEY_EQ, SHOW, 16'h0123, 16'h0045, OP_ADD, 16'h0168, 1'b0, 1);
    addVec(KEY_CE, ENTER_A, 16'h0000, 16'h0000, OP_NONE, 16'h0000, 1'b0, 0);
    addVec(4'h1, ENTER_A, 16'h0001, 16'h0000, OP_NONE, 16'h0001, 1'b0, 0);
    addVec(4'h2, ENTER_A, 16'h0012, 16'h0000, OP_NONE, 16'h0012, 1'b0, 0);
    addVec(KEY_SUB, ENTER_B, 16'h0012, 16'h0000, OP_SUB, 16'h0000, 1'b0, 0);
    addVec(4'h3, ENTER_B, 16'h0012, 16'h0003, OP_SUB, 16'h0003, 1'b0, 0);
    addVec(4'h4, ENTER_B, 16'h0012, 16'h0034, OP_SUB, 16'h0034, 1'b0, 0);
    addVec(4'h5, ENTER_B, 16'h0012, 16'h0345, OP_SUB, 16'h0345, 1'b0, 0);
    addVec(KEY_EQ, SHOW, 16'h0012, 16'h0345, OP_SUB, 16'h0333, 1'b1, 1);
    addVec(KEY_ADD, SHOW, 16'h0012, 16'h0345, OP_SUB, 16'h0333, 1'b1, 0);
    addVec(KEY_CE, ENTER_A, 16'h0000, 16'h0000, OP_NONE, 16'h0000, 1'b0, 0);
    addVec(4'h1, ENTER_A, 16'h0001, 16'h0000, OP_NONE, 16'h0001, 1'b0, 0);
    addVec(4'h2, ENTER_A, 16'h0012, 16'h0000, OP_NONE, 16'h0012, 1'b0, 0);
    addVec(4'h3, ENTER_A, 16'h0123, 16'h0000, OP_NONE, 16'h0123, 1'b0, 0);
    addVec(4'h4, ENTER_A, 16'h0123, 16'h0000, OP_NONE, 16'h0123, 1'b0, 0);
    addVec(KEY_CE, ENTER_A, 16'h0000, 16'h0000, OP_NONE, 16'h0000, 1'b0, 0);
    addVec(4'h0, ENTER_A, 16'h0000, 16'h0000, OP_NONE, 16'h0000, 1'b0, 0);
    addVec(4'h0, ENTER_A, 16'h0000, 16'h0000, OP_NONE, 16'h0000, 1'b0, 0);
    addVec(4'h0, ENTER_A, 16'h0000, 16'h0000, OP_NONE, 16'h0000, 1'b0, 0);
    addVec(4'h1, ENTER_A, 16'h0000, 16'h0000, OP_NONE, 16'h0000, 1'b0, 0);
    addVec(KEY_CE, ENTER_A, 16'h0000, 16'h0000, OP_NONE, 16'h0000, 1'b0, 0);
    addVec(4'h5, ENTER_A, 16'h0005, 16'h0000, OP_NONE, 16'h0005, 1'b0, 0);
    addVec(4'h0, ENTER_A, 16'h0050, 16'h0000, OP_NONE, 16'h0050, 1'b0, 0);
    addVec(4'h0, ENTER_A, 16'h0500, 16'h0000, OP_NONE, 16'h0500, 1'b0, 0);
    addVec(KEY_ADD, ENTER_B, 16'h0500, 16'h0000, OP_ADD, 16'h0000, 1'b0, 0);
    addVec(4'h5, ENTER_B, 16'h0500, 16'h0005, OP_ADD, 16'h0005, 1'b0, 0);
    addVec(4'h0, ENTER_B, 16'h0500, 16'h0050, OP_ADD, 16'h0050, 1'b0, 0);
    addVec(4'h0, ENTER_B, 16'h0500, 16'h0500, OP_ADD, 16'h0500, 1'b0, 0);
    addVec(KEY_EQ, SHOW, 16'h0500, 16'h0500, OP_ADD, 16'h1000, 1'b0, 1);
    addVec(KEY_ADD, SHOW, 16'h0500, 16'h0500, OP_ADD, 16'h1000, 1'b0, 0);
    addVec(4'h7, ENTER_A, 16'h0007, 16'h0000, OP_NONE, 16'h0007, 1'b0, 0);
    addVec(KEY_CE, ENTER_A, 16'h0000, 16'h0000, OP_NONE, 16'h0000, 1'b0, 0);
    addVec(4'h2, ENTER_A, 16'h0002, 16'h0000, OP_NONE, 16'h0002, 1'b0, 0);
    addVec(4'h0, ENTER_A, 16'h0020, 16'h0000, OP_NONE, 16'h0020, 1'b0, 0);
    addVec(KEY_ADD, ENTER_B, 16'h0020, 16'h0000, OP_ADD, 16'h0000, 1'b0, 0);
    addVec(4'h5, ENTER_B, 16'h0020, 16'h0005, OP_ADD, 16'h0005, 1'b0, 0);
    addVec(KEY_EQ, SHOW, 16'h0020, 16'h0005, OP_ADD, 16'h0025, 1'b0, 1);
    addVec(KEY_ADD, ENTER_B, 16'h0025, 16'h0000, OP_ADD, 16'h0000, 1'b0, 0);
    addVec(KEY_SUB, ENTER_B, 16'h0025, 16'h0000, OP_SUB, 16'h0000, 1'b0, 0);
    addVec(4'h3, ENTER_B, 16'h0025, 16'h0003, OP_SUB, 16'h0003, 1'b0, 0);
    addVec(KEY_ADD, ENTER_B, 16'h0025, 16'h0003, OP_SUB, 16'h0003, 1'b0, 0);
    addVec(KEY_EQ, SHOW, 16'h0025, 16'h0003, OP_SUB, 16'h0022, 1'b0, 1);
    addVec(KEY_EQ, SHOW, 16'h0025, 16'h0003, OP_SUB, 16'h0022, 1'b0, 1);
    addVec(KEY_CE, ENTER_A, 16'h0000, 16'h0000, OP_NONE, 16'h0000, 1'b0, 0);
    addVec(KEY_EQ, ENTER_A, 16'h0000, 16'h0000, OP_NONE, 16'h0000, 1'b0, 0);
    addVec(4'hE, ENTER_A, 16'h0000, 16'h0000, OP_NONE, 16'h0000, 1'b0, 0);
    addVec(4'h4, ENTER_A, 16'h0004, 16'h0000, OP_NONE, 16'h0004, 1'b0, 0);
    addVec(KEY_ADD, ENTER_B, 16'h0004, 16'h0000, OP_ADD, 16'h0000, 1'b0, 0);
    addVec(KEY_EQ, SHOW, 16'h0004, 16'h0000, OP_ADD, 16'h0004, 1'b0, 1);
    addVec(4'hF, SHOW, 16'h0004, 16'h0000, OP_ADD, 16'h0004, 1'b0, 0);

    // Reset state, checked while reset is held and just after release
    repeat (2) @(negedge clk);
    checkOutput("rst state", 16'(dut1.r_state), 16'(ENTER_A));
    checkOutput("rst bcd1", bus1.bcd1, 16'h0000);
    checkOutput("rst bcd2", bus1.bcd2, 16'h0000);
    checkOutput("rst op", 16'(bus1.op_selected), 16'(OP_NONE));
    checkOutput("rst enable", 16'(bus1.alu_enable), 16'(ALU_EN_OFF));
    checkOutput("rst disp", bus1.disp_bcd, 16'h0000);
    checkOutput("rst neg", 16'(bus1.disp_neg), 16'h0000);
    checkOutput("rst busy", 16'(bus1.busy), 16'h0000);
    clear_n = 1'b1;
    @(negedge clk);
    checkOutput("rst key_ready", 16'(bus1.key_ready), 16'h0001);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      int en0;
      v = vecs[i];
      en0 = enTotal1;
      applyStimulus(v.key);
      checkOutput($sformatf("v%0d state", i), 16'(dut1.r_state), 16'(v.st));
      checkOutput($sformatf("v%0d bcd1", i), bus1.bcd1, v.bcd1);
      checkOutput($sformatf("v%0d bcd2", i), bus1.bcd2, v.bcd2);
      checkOutput($sformatf("v%0d op", i), 16'(bus1.op_selected), 16'(v.op));
      checkOutput($sformatf("v%0d disp", i), bus1.disp_bcd, v.disp);
      checkOutput($sformatf("v%0d neg", i), 16'(bus1.disp_neg), 16'(v.neg));
      checkOutput($sformatf("v%0d enable pulses", i), 16'(enTotal1 - en0), 16'(v.en));
    end

    // ALU_LAT=4: key dropped during WAIT, capture exactly 5 edges after EXEC begins
    applyStimulus(KEY_CE);
    applyStimulus(4'h2);
    applyStimulus(KEY_ADD);
    applyStimulus(4'h3);
    @(negedge clk);
    setKey(1'b1, KEY_EQ);
    @(posedge clk);
    #1 setKey(1'b0, 4'h0);
    checkOutput("lat4 exec state", 16'(dut4.r_state), 16'(EXEC));
    checkOutput("lat4 exec enable", 16'(bus4.alu_enable), 16'(ALU_EN_ON));
    checkOutput("lat4 exec busy", 16'(bus4.busy), 16'h0001);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) setKey(1'b1, 4'h3);
      if (k == 3) setKey(1'b0, 4'h0);
      checkOutput($sformatf("lat4 wait%0d state", k), 16'(dut4.r_state), 16'(WAIT));
      checkOutput($sformatf("lat4 wait%0d enable", k), 16'(bus4.alu_enable), 16'(ALU_EN_OFF));
      checkOutput($sformatf("lat4 wait%0d disp", k), bus4.disp_bcd, 16'h0003);
      if (k == 2) checkOutput("lat4 key_ready", 16'(bus4.key_ready), 16'h0000);
    end
    @(posedge clk);
    #1;
    checkOutput("lat4 show state", 16'(dut4.r_state), 16'(SHOW));
    checkOutput("lat4 show disp", bus4.disp_bcd, 16'h0005);
    checkOutput("lat4 show neg", 16'(bus4.disp_neg), 16'h0000);
    checkOutput("lat4 bcd2 kept", bus4.bcd2, 16'h0003);
    checkOutput("lat4 show ready", 16'(bus4.key_ready), 16'h0001);
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of an execution
    applyStimulus(KEY_CE);
    applyStimulus(4'h1);
    applyStimulus(KEY_ADD);
    applyStimulus(4'h2);
    @(negedge clk);
    setKey(1'b1, KEY_EQ);
    @(posedge clk);
    #1 setKey(1'b0, 4'h0);
    checkOutput("arst pre enable", 16'(bus4.alu_enable), 16'(ALU_EN_ON));
    #2 clear_n = 1'b0;
    #1;
    checkOutput("arst enable", 16'(bus4.alu_enable), 16'(ALU_EN_OFF));
    checkOutput("arst op", 16'(bus4.op_selected), 16'(OP_NONE));
    checkOutput("arst disp", bus4.disp_bcd, 16'h0000);
    checkOutput("arst busy", 16'(bus4.busy), 16'h0000);
    checkOutput("arst bcd1", bus4.bcd1, 16'h0000);
    checkOutput("arst state", 16'(dut4.r_state), 16'(ENTER_A));
    @(negedge clk);
    clear_n = 1'b1;
    applyStimulus(4'h9);
    checkOutput("arst next bcd1", bus4.bcd1, 16'h0009);
    checkOutput("arst next state", 16'(dut4.r_state), 16'(ENTER_A));
    checkOutput("arst next ready", 16'(bus4.key_ready), 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
